// File: rtl/cam_pkg.sv
// Shared constants for the YUV camera capture block: default parameter
// values, capture FSM state encodings and byte-order encodings.
package cam_pkg;

  localparam int CAM_DW         = 8;
  localparam int CAM_H_ACTIVE   = 640;
  localparam int CAM_V_ACTIVE   = 480;
  localparam int CAM_ADDR_W     = 20;
  localparam int CAM_FIFO_DEPTH = 4;

  // Capture FSM state encodings (kept as plain constants for legacy tools).
  typedef logic [1:0] cam_state_t;
  localparam cam_state_t ST_WAIT_VS = 2'd0;
  localparam cam_state_t ST_SYNC    = 2'd1;
  localparam cam_state_t ST_LINE    = 2'd2;
  localparam cam_state_t ST_GAP     = 2'd3;

  // Byte order of a 4-byte quad on the camera bus.
  typedef enum logic [1:0] {
    ORD_CBYCRY = 2'd0,
    ORD_YCBYCR = 2'd1,
    ORD_CRYCBY = 2'd2,
    ORD_YCRYCB = 2'd3
  } cam_order_e;

endpackage

// File: rtl/cam_pair_fifo.sv
// Synchronous show-ahead FIFO holding packed YUV pixel pairs.
// The head entry is visible on rd_data whenever empty is low (zero when
// empty). A write while full is accepted only if a read happens in the
// same cycle, which frees the slot being written.
module cam_pair_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_wr;
  logic          do_rd;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/cam_capture_yuv.sv
// YUV 4:2:2 camera capture: assembles byte quads from a DVP-style bus into
// pixel pairs with frame addresses and queues them for a downstream consumer.
// Optional macro CAM_CAPTURE_WINDOW_EN adds a capture window (win_* ports);
// pairs outside the window are silently discarded and addresses/sof/eol are
// then relative to the window origin.
//
// Output handshake: a pair transfers on a rising PCLK edge where out_valid
// and out_ready are both high. While out_valid is high and out_ready low,
// all pair outputs hold; out_valid never drops without a transfer.
module cam_capture_yuv
  import cam_pkg::*;
#(
  parameter int DW         = CAM_DW,
  parameter int H_ACTIVE   = CAM_H_ACTIVE,
  parameter int V_ACTIVE   = CAM_V_ACTIVE,
  parameter int ADDR_W     = CAM_ADDR_W,
  parameter int FIFO_DEPTH = CAM_FIFO_DEPTH
) (
  input  logic              PCLK,
  input  logic              RESET,
  input  logic              VSYNC,
  input  logic              HREF,
  input  logic [DW-1:0]     D,
  input  logic              enable,
  input  logic [1:0]        order,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_y0,
  output logic [DW-1:0]     out_y1,
  output logic [DW-1:0]     out_cb,
  output logic [DW-1:0]     out_cr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_sof,
  output logic              out_eol,
  output logic [7:0]        frame_cnt,
  output logic              overflow,
  output logic              line_err
`ifdef CAM_CAPTURE_WINDOW_EN
  ,
  input  logic [ADDR_W-1:0] win_x0,
  input  logic [ADDR_W-1:0] win_y0,
  input  logic [ADDR_W-1:0] win_w,
  input  logic [ADDR_W-1:0] win_h
`endif
);

  localparam int PW = ADDR_W + 2 + 4*DW;
  localparam logic [ADDR_W-1:0] H_LIM = ADDR_W'(H_ACTIVE);
  localparam logic [ADDR_W-1:0] V_LIM = ADDR_W'(V_ACTIVE);

  cam_state_t        state;
  cam_state_t        state_nxt;
  logic [1:0]        idx;
  logic [DW-1:0]     b0, b1, b2;
  cam_order_e        qord;
  logic [ADDR_W-1:0] x, y, row_base, row_step;
  logic              line_has_quad;

  logic              capture, quad_done, line_end, frame_end;
  logic              in_frame, in_win, pair_wr;
  logic [DW-1:0]     p_y0, p_y1, p_cb, p_cr;
  logic [ADDR_W-1:0] p_addr;
  logic              p_sof, p_eol;
  logic [PW-1:0]     wr_data, rd_data;
  logic              fifo_full, fifo_empty, fifo_rd;

  // A byte is taken only inside a frame, on HREF-high cycles.
  assign capture   = enable && !VSYNC && HREF && (state == ST_GAP || state == ST_LINE);
  assign line_end  = enable && !VSYNC && !HREF && (state == ST_LINE);
  assign frame_end = enable && VSYNC && (state == ST_GAP || state == ST_LINE);
  assign quad_done = capture && (idx == 2'd3);
  assign in_frame  = (x < H_LIM) && (y < V_LIM);
  assign pair_wr   = quad_done && in_frame && in_win;

`ifdef CAM_CAPTURE_WINDOW_EN
  logic win_row_hit;
  assign win_row_hit = (y >= win_y0) && (y < win_y0 + win_h);
  assign in_win      = win_row_hit && (x >= win_x0) && (x < win_x0 + win_w);
  assign row_step    = win_row_hit ? win_w : '0;
  assign p_addr      = row_base + (x - win_x0);
  assign p_sof       = (x == win_x0) && (y == win_y0);
  assign p_eol       = (x == win_x0 + win_w - ADDR_W'(2));
`else
  localparam logic [ADDR_W-1:0] EOL_X = ADDR_W'(H_ACTIVE - 2);
  assign in_win   = 1'b1;
  assign row_step = H_LIM;
  assign p_addr   = row_base + x;
  assign p_sof    = (x == '0) && (y == '0);
  assign p_eol    = (x == EOL_X);
`endif

  // Next-state logic; dropping enable always returns to waiting for VSYNC.
  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = ST_WAIT_VS;
    end else begin
      case (state)
        ST_WAIT_VS: if (VSYNC) state_nxt = ST_SYNC;
        ST_SYNC:    if (!VSYNC) state_nxt = ST_GAP;
        ST_GAP:     if (VSYNC) state_nxt = ST_SYNC;
                    else if (HREF) state_nxt = ST_LINE;
        ST_LINE:    if (VSYNC) state_nxt = ST_SYNC;
                    else if (!HREF) state_nxt = ST_GAP;
        default:    state_nxt = ST_WAIT_VS;
      endcase
    end
  end

  // State register.
  always_ff @(posedge PCLK) begin
    if (!RESET) state <= ST_WAIT_VS;
    else        state <= state_nxt;
  end

  // Byte index and quad assembly; any non-capture cycle restarts the quad.
  always_ff @(posedge PCLK) begin
    if (!RESET) begin
      idx  <= 2'd0;
      b0   <= '0;
      b1   <= '0;
      b2   <= '0;
      qord <= ORD_CBYCRY;
    end else if (capture) begin
      idx <= idx + 2'd1;
      case (idx)
        2'd0: begin
          b0   <= D;
          qord <= cam_order_e'(order);
        end
        2'd1:    b1 <= D;
        2'd2:    b2 <= D;
        default: b2 <= b2;
      endcase
    end else begin
      idx <= 2'd0;
    end
  end

  // Map the completed quad onto pair components using the order latched at byte 0.
  always_comb begin
    p_y0 = '0;
    p_y1 = '0;
    p_cb = '0;
    p_cr = '0;
    case (qord)
      ORD_CBYCRY: begin p_cb = b0; p_y0 = b1; p_cr = b2; p_y1 = D; end
      ORD_YCBYCR: begin p_y0 = b0; p_cb = b1; p_y1 = b2; p_cr = D; end
      ORD_CRYCBY: begin p_cr = b0; p_y0 = b1; p_cb = b2; p_y1 = D; end
      ORD_YCRYCB: begin p_y0 = b0; p_cr = b1; p_y1 = b2; p_cb = D; end
      default:    begin p_y0 = '0; end
    endcase
  end

  // Pixel position; x and row_base advance incrementally, saturating past the frame.
  always_ff @(posedge PCLK) begin
    if (!RESET || frame_end || !(state == ST_LINE || state == ST_GAP)) begin
      x             <= '0;
      y             <= '0;
      row_base      <= '0;
      line_has_quad <= 1'b0;
    end else if (quad_done) begin
      line_has_quad <= 1'b1;
      if (x < H_LIM) x <= x + ADDR_W'(2);
    end else if (line_end) begin
      x             <= '0;
      line_has_quad <= 1'b0;
      if (line_has_quad && (y < V_LIM)) begin
        y        <= y + ADDR_W'(1);
        row_base <= row_base + row_step;
      end
    end
  end

  // Completed-frame counter, bumped when VSYNC rises inside a frame.
  always_ff @(posedge PCLK) begin
    if (!RESET)         frame_cnt <= 8'd0;
    else if (frame_end) frame_cnt <= frame_cnt + 8'd1;
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge PCLK) begin
    if (!RESET) begin
      overflow <= 1'b0;
      line_err <= 1'b0;
    end else begin
      if (pair_wr && fifo_full && !fifo_rd) overflow <= 1'b1;
      if ((quad_done && !in_frame) || (line_end && idx != 2'd0)) line_err <= 1'b1;
    end
  end

  assign wr_data   = {p_addr, p_sof, p_eol, p_y0, p_y1, p_cb, p_cr};
  assign out_valid = !fifo_empty;
  assign fifo_rd   = out_valid && out_ready;
  assign {out_addr, out_sof, out_eol, out_y0, out_y1, out_cb, out_cr} = rd_data;

  cam_pair_fifo #(
    .W     (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (PCLK),
    .rst_n   (RESET),
    .wr_en   (pair_wr),
    .wr_data (wr_data),
    .rd_en   (fifo_rd),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_cam_capture_yuv.sv
// Directed bench for cam_capture_yuv with a 4x2 frame and a 4-entry FIFO.
module tb_cam_capture_yuv;

  localparam int DW = 8;
  localparam int AW = 20;
  localparam int PW = AW + 2 + 4*DW;

  logic          PCLK;
  logic          RESET;
  logic          VSYNC;
  logic          HREF;
  logic [DW-1:0] D;
  logic          enable;
  logic [1:0]    order;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_y0, out_y1, out_cb, out_cr;
  logic [AW-1:0] out_addr;
  logic          out_sof, out_eol;
  logic [7:0]    frame_cnt;
  logic          overflow, line_err;
`ifdef CAM_CAPTURE_WINDOW_EN
  logic [AW-1:0] win_x0, win_y0, win_w, win_h;
`endif

  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] got_q[$];
  logic [7:0]    line_buf [16];
  logic [PW-1:0] head;
  int            n_checks;
  int            n_pass;

  cam_capture_yuv #(
    .DW(DW), .H_ACTIVE(4), .V_ACTIVE(2), .ADDR_W(AW), .FIFO_DEPTH(4)
  ) dut (
    .PCLK(PCLK), .RESET(RESET), .VSYNC(VSYNC), .HREF(HREF), .D(D),
    .enable(enable), .order(order), .out_valid(out_valid), .out_ready(out_ready),
    .out_y0(out_y0), .out_y1(out_y1), .out_cb(out_cb), .out_cr(out_cr),
    .out_addr(out_addr), .out_sof(out_sof), .out_eol(out_eol),
    .frame_cnt(frame_cnt), .overflow(overflow), .line_err(line_err)
`ifdef CAM_CAPTURE_WINDOW_EN
    , .win_x0(win_x0), .win_y0(win_y0), .win_w(win_w), .win_h(win_h)
`endif
  );

  // Clock
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Record every pair transfer, sampled mid-cycle.
  always @(negedge PCLK) begin
    if (RESET && out_valid && out_ready)
      got_q.push_back({out_addr, out_sof, out_eol, out_y0, out_y1, out_cb, out_cr});
  end

  function automatic logic [PW-1:0] mk(input logic [7:0] y0, input logic [7:0] y1,
                                       input logic [7:0] cb, input logic [7:0] cr,
                                       input logic [AW-1:0] a, input logic s, input logic e);
    return {a, s, e, y0, y1, cb, cr};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic do_reset();
    RESET = 1'b0; VSYNC = 1'b0; HREF = 1'b0; D = '0;
    enable = 1'b1; order = 2'd0; out_ready = 1'b1;
`ifdef CAM_CAPTURE_WINDOW_EN
    win_x0 = '0; win_y0 = '0; win_w = 20'd4; win_h = 20'd2;
`endif
    tick(3);
    RESET = 1'b1;
    tick(1);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic send_vsync();
    VSYNC = 1'b1;
    tick(3);
    VSYNC = 1'b0;
    tick(3);
  endtask

  task automatic send_line(input int n);
    for (int i = 0; i < n; i++) begin
      HREF = 1'b1;
      D = line_buf[i];
      tick(1);
    end
    HREF = 1'b0;
    D = '0;
    tick(4);
  endtask

  task automatic push_full_frame();
    exp_q.push_back(mk(8'h10, 8'h20, 8'h80, 8'h7F, 20'd0, 1'b1, 1'b0));
    exp_q.push_back(mk(8'h30, 8'h40, 8'h81, 8'h82, 20'd2, 1'b0, 1'b1));
    exp_q.push_back(mk(8'h10, 8'h20, 8'h80, 8'h7F, 20'd4, 1'b0, 1'b0));
    exp_q.push_back(mk(8'h30, 8'h40, 8'h81, 8'h82, 20'd6, 1'b0, 1'b1));
  endtask

  task automatic test_reset();
    do_reset();
    out_ready = 1'b0;
    send_vsync();
    send_line(6);
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL rst_pre_valid got %b want 1", out_valid); else n_pass++;
    n_checks++;
    if (line_err !== 1'b1) $display("FAIL rst_pre_line_err got %b want 1", line_err); else n_pass++;
    RESET = 1'b0;
    tick(2);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", out_valid); else n_pass++;
    n_checks++;
    if ({out_addr, out_sof, out_eol, out_y0, out_y1, out_cb, out_cr} !== '0)
      $display("FAIL rst_outputs got %h want 0", {out_addr, out_sof, out_eol, out_y0, out_y1, out_cb, out_cr});
    else n_pass++;
    n_checks++;
    if (frame_cnt !== 8'd0) $display("FAIL rst_frame_cnt got %0d want 0", frame_cnt); else n_pass++;
    n_checks++;
    if ({overflow, line_err} !== 2'b00) $display("FAIL rst_flags got %b want 00", {overflow, line_err}); else n_pass++;
    RESET = 1'b1;
    tick(1);
  endtask

  task automatic test_basic();
    do_reset();
    push_full_frame();
    send_vsync();
    send_line(8);
    send_line(8);
    send_vsync();
    tick(5);
    n_checks++;
    if (got_q.size() != exp_q.size()) $display("FAIL basic_count got %0d want %0d", got_q.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= got_q.size()) $display("FAIL basic_pair%0d got none want %h", i, exp_q[i]);
      else if (got_q[i] !== exp_q[i]) $display("FAIL basic_pair%0d got %h want %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (frame_cnt !== 8'd1) $display("FAIL basic_frame_cnt got %0d want 1", frame_cnt); else n_pass++;
    n_checks++;
    if ({overflow, line_err} !== 2'b00) $display("FAIL basic_flags got %b want 00", {overflow, line_err}); else n_pass++;
  endtask

  task automatic test_order();
    logic [PW-1:0] want;
    for (int ord = 1; ord < 4; ord++) begin
      do_reset();
      order = 2'(ord);
      case (ord)
        1:       want = mk(8'h80, 8'h7F, 8'h10, 8'h20, 20'd0, 1'b1, 1'b0);
        2:       want = mk(8'h10, 8'h20, 8'h7F, 8'h80, 20'd0, 1'b1, 1'b0);
        default: want = mk(8'h80, 8'h7F, 8'h20, 8'h10, 20'd0, 1'b1, 1'b0);
      endcase
      send_vsync();
      send_line(8);
      send_line(8);
      tick(5);
      n_checks++;
      if (got_q.size() != 4) $display("FAIL order%0d_count got %0d want 4", ord, got_q.size()); else n_pass++;
      n_checks++;
      if (got_q.size() == 0) $display("FAIL order%0d_first got none want %h", ord, want);
      else if (got_q[0] !== want) $display("FAIL order%0d_first got %h want %h", ord, got_q[0], want);
      else n_pass++;
    end
  endtask

  task automatic test_overflow();
    do_reset();
    out_ready = 1'b0;
    push_full_frame();
    send_vsync();
    send_line(8);
    send_line(8);
    send_vsync();
    send_line(8);
    tick(2);
    n_checks++;
    if (overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", overflow); else n_pass++;
    head = {out_addr, out_sof, out_eol, out_y0, out_y1, out_cb, out_cr};
    n_checks++;
    if (head !== exp_q[0]) $display("FAIL ovf_head got %h want %h", head, exp_q[0]); else n_pass++;
    tick(5);
    head = {out_addr, out_sof, out_eol, out_y0, out_y1, out_cb, out_cr};
    n_checks++;
    if (out_valid !== 1'b1 || head !== exp_q[0]) $display("FAIL ovf_hold got %b/%h want 1/%h", out_valid, head, exp_q[0]); else n_pass++;
    out_ready = 1'b1;
    tick(10);
    n_checks++;
    if (got_q.size() != 4) $display("FAIL ovf_count got %0d want 4", got_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= got_q.size()) $display("FAIL ovf_pair%0d got none want %h", i, exp_q[i]);
      else if (got_q[i] !== exp_q[i]) $display("FAIL ovf_pair%0d got %h want %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL ovf_drained got %b want 0", out_valid); else n_pass++;
    // A clean frame afterwards must not clear the sticky flag.
    send_vsync();
    send_line(8);
    tick(3);
    n_checks++;
    if (got_q.size() != 6) $display("FAIL ovf_after_count got %0d want 6", got_q.size()); else n_pass++;
    n_checks++;
    if ({overflow, line_err} !== 2'b10) $display("FAIL ovf_sticky got %b want 10", {overflow, line_err}); else n_pass++;
  endtask

  task automatic test_line_err();
    do_reset();
    send_vsync();
    n_checks++;
    if (line_err !== 1'b0) $display("FAIL lerr_init got %b want 0", line_err); else n_pass++;
    send_line(6);
    tick(2);
    exp_q.push_back(mk(8'h10, 8'h20, 8'h80, 8'h7F, 20'd0, 1'b1, 1'b0));
    n_checks++;
    if (got_q.size() != 1) $display("FAIL lerr6_count got %0d want 1", got_q.size()); else n_pass++;
    n_checks++;
    if (got_q.size() == 0) $display("FAIL lerr6_pair got none want %h", exp_q[0]);
    else if (got_q[0] !== exp_q[0]) $display("FAIL lerr6_pair got %h want %h", got_q[0], exp_q[0]);
    else n_pass++;
    n_checks++;
    if (line_err !== 1'b1) $display("FAIL lerr6_flag got %b want 1", line_err); else n_pass++;

    do_reset();
    send_vsync();
    send_line(12);
    tick(2);
    exp_q.push_back(mk(8'h10, 8'h20, 8'h80, 8'h7F, 20'd0, 1'b1, 1'b0));
    exp_q.push_back(mk(8'h30, 8'h40, 8'h81, 8'h82, 20'd2, 1'b0, 1'b1));
    n_checks++;
    if (got_q.size() != 2) $display("FAIL lerr12_count got %0d want 2", got_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= got_q.size()) $display("FAIL lerr12_pair%0d got none want %h", i, exp_q[i]);
      else if (got_q[i] !== exp_q[i]) $display("FAIL lerr12_pair%0d got %h want %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (line_err !== 1'b1) $display("FAIL lerr12_flag got %b want 1", line_err); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_vsync();
    for (int i = 0; i < 6; i++) begin
      HREF = 1'b1;
      D = line_buf[i];
      tick(1);
    end
    RESET = 1'b0;
    D = line_buf[6];
    tick(2);
    got_q.delete();
    RESET = 1'b1;
    D = line_buf[7];
    tick(1);
    HREF = 1'b0;
    D = '0;
    tick(4);
    send_line(8);
    tick(3);
    n_checks++;
    if (got_q.size() != 0) $display("FAIL rmid_silent got %0d want 0", got_q.size()); else n_pass++;
    send_vsync();
    send_line(8);
    tick(3);
    exp_q.push_back(mk(8'h10, 8'h20, 8'h80, 8'h7F, 20'd0, 1'b1, 1'b0));
    exp_q.push_back(mk(8'h30, 8'h40, 8'h81, 8'h82, 20'd2, 1'b0, 1'b1));
    n_checks++;
    if (got_q.size() != 2) $display("FAIL rmid_count got %0d want 2", got_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= got_q.size()) $display("FAIL rmid_pair%0d got none want %h", i, exp_q[i]);
      else if (got_q[i] !== exp_q[i]) $display("FAIL rmid_pair%0d got %h want %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_enable();
    do_reset();
    out_ready = 1'b0;
    send_vsync();
    send_line(8);
    enable = 1'b0;
    tick(2);
    send_vsync();
    send_line(8);
    out_ready = 1'b1;
    tick(6);
    exp_q.push_back(mk(8'h10, 8'h20, 8'h80, 8'h7F, 20'd0, 1'b1, 1'b0));
    exp_q.push_back(mk(8'h30, 8'h40, 8'h81, 8'h82, 20'd2, 1'b0, 1'b1));
    n_checks++;
    if (got_q.size() != 2) $display("FAIL en_count got %0d want 2", got_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= got_q.size()) $display("FAIL en_pair%0d got none want %h", i, exp_q[i]);
      else if (got_q[i] !== exp_q[i]) $display("FAIL en_pair%0d got %h want %h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (frame_cnt !== 8'd0) $display("FAIL en_frame_cnt got %0d want 0", frame_cnt); else n_pass++;
  endtask

`ifdef CAM_CAPTURE_WINDOW_EN
  task automatic test_window();
    do_reset();
    win_x0 = 20'd2; win_y0 = 20'd1; win_w = 20'd2; win_h = 20'd1;
    send_vsync();
    send_line(8);
    send_line(8);
    tick(3);
    exp_q.push_back(mk(8'h30, 8'h40, 8'h81, 8'h82, 20'd0, 1'b1, 1'b1));
    n_checks++;
    if (got_q.size() != 1) $display("FAIL win_count got %0d want 1", got_q.size()); else n_pass++;
    n_checks++;
    if (got_q.size() == 0) $display("FAIL win_pair got none want %h", exp_q[0]);
    else if (got_q[0] !== exp_q[0]) $display("FAIL win_pair got %h want %h", got_q[0], exp_q[0]);
    else n_pass++;
    n_checks++;
    if (line_err !== 1'b0) $display("FAIL win_line_err got %b want 0", line_err); else n_pass++;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_pass   = 0;
    RESET = 1'b0; VSYNC = 1'b0; HREF = 1'b0; D = '0;
    enable = 1'b0; order = 2'd0; out_ready = 1'b0;
`ifdef CAM_CAPTURE_WINDOW_EN
    win_x0 = '0; win_y0 = '0; win_w = 20'd4; win_h = 20'd2;
`endif
    line_buf = '{8'h80, 8'h10, 8'h7F, 8'h20, 8'h81, 8'h30, 8'h82, 8'h40,
                 8'h83, 8'h50, 8'h84, 8'h60, 8'h00, 8'h00, 8'h00, 8'h00};
    test_reset();
    test_basic();
    test_order();
    test_overflow();
    test_line_err();
    test_reset_mid();
    test_enable();
`ifdef CAM_CAPTURE_WINDOW_EN
    test_window();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cam_capture_yuv.md
CAM_CAPTURE_YUV -- requirements
Module: cam_capture_yuv

Interface
REQ-001 SHALL have parameter DW, default 8, meaning camera data bus width.
REQ-002 SHALL have parameter H_ACTIVE, default 640, meaning active pixels per line (even).
REQ-003 SHALL have parameter V_ACTIVE, default 480, meaning active lines per frame.
REQ-004 SHALL have parameter ADDR_W, default 20, meaning pixel address width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, meaning output pair FIFO entries (power of 2, >=2).
REQ-006 SHALL have ports, in order:
  PCLK  in  1  pixel clock; all logic on rising edge
  RESET  in  1  synchronous, active-low reset
  VSYNC  in  1  frame sync, high between frames
  HREF  in  1  line valid
  D  in  DW  camera byte
  enable  in  1  capture enable
  order  in  2  byte order: 0 CbYCrY, 1 YCbYCr, 2 CrYCbY, 3 YCrYCb
  out_valid  out  1  pair available
  out_ready  in  1  consumer accepts pair
  out_y0, out_y1, out_cb, out_cr  out  DW each  pair components, raw offset-binary
  out_addr  out  ADDR_W  address of first pixel of pair
  out_sof, out_eol  out  1 each  first pair of frame / last pair of line
  frame_cnt  out  8  completed frames
  overflow, line_err  out  1 each  sticky error flags

Function
REQ-010 FSM SHALL have states WAIT_VS, SYNC, LINE, GAP.
REQ-011 WAIT_VS -> SYNC when VSYNC=1 and enable=1; SYNC -> GAP when VSYNC=0; GAP -> LINE when HREF=1; LINE -> GAP when HREF=0; LINE/GAP -> SYNC when VSYNC=1; any state -> WAIT_VS when enable=0.
REQ-012 Capture SHALL begin only after a complete VSYNC pulse; partial frame after reset or enable SHALL be discarded.
REQ-013 Byte index (0..3) SHALL be 0 on the first HREF=1 byte of each line and advance by 1 per HREF=1 byte, wrapping 3->0.
REQ-014 Bytes SHALL map to Y0/Y1/Cb/Cr per order, sampled at the start of each quad.
REQ-015 On the edge sampling byte 3, pair SHALL be written to FIFO; out_valid SHALL be high the following cycle when FIFO was empty.
REQ-016 Pair transfer SHALL occur on out_valid=1 and out_ready=1; outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-017 x SHALL advance by 2 per pair; y by 1 per HREF fall with >=1 pair; out_addr = y*H_ACTIVE + x, computed incrementally, no multiplier.
REQ-018 out_sof SHALL be 1 for pair (x=0, y=0); out_eol for x = H_ACTIVE-2.
REQ-019 Pairs with x >= H_ACTIVE or y >= V_ACTIVE SHALL be dropped and set line_err.
REQ-020 HREF fall with byte index != 0 SHALL drop the partial quad and set line_err.
REQ-021 VSYNC rise in LINE mid-quad SHALL abort the line; no partial pair written.
REQ-022 frame_cnt SHALL increment on LINE/GAP -> SYNC, wrapping 255 -> 0; x, y SHALL clear.
REQ-023 Write while FIFO full SHALL drop the pair and set overflow, unless a transfer occurs that same cycle, in which case the write SHALL succeed.
REQ-024 order change SHALL take effect at next quad start; enable=0 SHALL not flush the FIFO.

Reset
REQ-030 RESET=0 at PCLK edge SHALL force: FSM WAIT_VS, byte index 0, x=y=0, FIFO empty, all outputs 0, overflow and line_err cleared.
REQ-031 Sticky flags SHALL clear only on reset.
REQ-032 Reset mid-frame SHALL discard in-flight data; capture resumes after next complete VSYNC pulse.

Configuration
REQ-040 Macro CAM_CAPTURE_WINDOW_EN defined: SHALL add inputs win_x0, win_y0, win_w, win_h (ADDR_W each, x values even); only pairs inside window are emitted, out_addr relative to window origin, sof/eol relative to window; outside pairs discarded without setting line_err.
REQ-041 Macro undefined: SHALL have no window ports and full-frame behaviour per REQ-017..019.

Structure
REQ-050 Package cam_pkg SHALL hold the state enum, order encodings, and default parameter constants.
REQ-051 FIFO SHALL be sub-module cam_pair_fifo (synchronous, show-ahead, full/empty, simultaneous read/write).

Verification (H_ACTIVE=4, V_ACTIVE=2, FIFO_DEPTH=4)
REQ-060 order=0, frame bytes 80,10,7F,20,81,30,82,40 x2 lines, out_ready=1 -> 4 pairs, first Y0=10 Y1=20 Cb=80 Cr=7F addr 0 sof=1; addrs 0,2,4,6; eol on 2,6; frame_cnt=1.
REQ-061 Same frame, order=1 -> first pair Y0=80 Y1=7F Cb=10 Cr=20.
REQ-062 out_ready=0, 6 pairs -> 4 in FIFO, overflow=1; out_ready=1 then -> exactly 4 pairs delivered, contents unchanged.
REQ-063 Line of 6 bytes -> 1 pair emitted, line_err=1; 12-byte line -> 2 pairs, line_err=1.
REQ-064 RESET=0 mid-line, then release mid-frame -> no output until next VSYNC pulse; next frame first pair sof=1, addr 0.
REQ-065 CAM_CAPTURE_WINDOW_EN, win=(2,1,2,1) -> single pair from x=2, y=1, addr 0, sof=1, eol=1.
